// File: rtl/mem_responder_pkg.sv
// Shared response codes and FSM state encodings for the memory responder.
package mem_responder_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/mem_responder.sv
// Small-word memory slave with independent read and write channels, a
// programmable read latency and a combinational backdoor port.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int MEM_DEPTH = 12,
    parameter int READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ar_valid,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 ar_ready,
    output logic                 r_valid,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 r_ready,
    input  logic                 aw_valid,
    input  logic [ADDR_WDTH-1:0] aw_address,
    output logic                 aw_ready,
    input  logic                 w_valid,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 w_ready,
    output logic                 b_valid,
    output logic [RESP_WDTH-1:0] b_resp,
    input  logic                 b_ready,
    input  logic                 dbg_we,
    input  logic [ADDR_WDTH-1:0] dbg_addr,
    input  logic [DATA_WDTH-1:0] dbg_wdata,
    output logic [DATA_WDTH-1:0] dbg_rdata
);

    function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
        return int'(a) < MEM_DEPTH;
    endfunction

    logic [DATA_WDTH-1:0] r_mem [MEM_DEPTH];

    rd_state_e            r_rstate, w_rnext;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic [ADDR_WDTH-1:0] r_araddr, w_raddr;
    logic                 w_rd_enter;

    wr_state_e            r_wstate, w_wnext;
    logic                 r_aw_got, r_w_got;
    logic [ADDR_WDTH-1:0] r_awaddr, w_waddr;
    logic [DATA_WDTH-1:0] r_wdata, w_wdat;
    logic                 w_aw_hs, w_w_hs, w_commit;

    always_comb begin
        w_rnext   = r_rstate;
        w_cnt_nxt = r_cnt;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    w_cnt_nxt = 4'(READ_LAT);
                    w_rnext   = (READ_LAT > 0) ? R_WAIT : R_RESP;
                end
            end
            R_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_rnext = R_RESP;
            end
            R_RESP: begin
                r_valid = 1'b1;
                if (r_ready) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // With zero latency the address is used on the same edge it is accepted.
    assign w_raddr    = (r_rstate == R_IDLE) ? ar_address : r_araddr;
    assign w_rd_enter = (w_rnext == R_RESP) && (r_rstate != R_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_cnt    <= '0;
            r_araddr <= '0;
            r_data   <= '0;
            r_resp   <= '0;
        end else begin
            r_rstate <= w_rnext;
            r_cnt    <= w_cnt_nxt;
            if (r_rstate == R_IDLE && ar_valid) r_araddr <= ar_address;
            if (w_rd_enter) begin
                r_data <= in_range(w_raddr) ? r_mem[w_raddr] : '0;
                r_resp <= in_range(w_raddr) ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
            end
        end
    end

    assign w_aw_hs  = aw_valid && (r_wstate == W_IDLE) && !r_aw_got;
    assign w_w_hs   = w_valid  && (r_wstate == W_IDLE) && !r_w_got;
    assign w_waddr  = r_aw_got ? r_awaddr : aw_address;
    assign w_wdat   = r_w_got  ? r_wdata  : w_data;
    assign w_commit = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

    always_comb begin
        w_wnext  = r_wstate;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                aw_ready = !r_aw_got;
                w_ready  = !r_w_got;
                if (w_commit) w_wnext = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (b_ready) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            b_resp   <= '0;
        end else begin
            r_wstate <= w_wnext;
            if (w_commit) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
                b_resp   <= in_range(w_waddr) ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
            end else begin
                if (w_aw_hs) begin
                    r_aw_got <= 1'b1;
                    r_awaddr <= aw_address;
                end
                if (w_w_hs) begin
                    r_w_got <= 1'b1;
                    r_wdata <= w_data;
                end
            end
        end
    end

    // Memory is never reset; the bus write is placed last so it wins over the backdoor.
    always_ff @(posedge clk) begin
        if (dbg_we && in_range(dbg_addr)) r_mem[dbg_addr] <= dbg_wdata;
        if (w_commit && in_range(w_waddr)) r_mem[w_waddr] <= w_wdat;
    end

    assign dbg_rdata = in_range(dbg_addr) ? r_mem[dbg_addr] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with read/write response scoreboards.
module tb_mem_responder;

    localparam int AW = 4, DW = 32, RW = 1, DEPTH = 12, RL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0] ar_address, aw_address, dbg_addr;
    logic [DW-1:0] r_data, w_data, dbg_wdata, dbg_rdata;
    logic [RW-1:0] r_resp, b_resp;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, dbg_we;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] resp;
    } rexp_t;

    rexp_t         rq[$];
    logic [RW-1:0] bq[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .MEM_DEPTH(DEPTH), .READ_LAT(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_address(ar_address), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .aw_valid(aw_valid), .aw_address(aw_address), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(posedge clk); #1;
        dbg_we = 1'b0;
    endtask

    task automatic dbg_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    task automatic issue_ar(input logic [AW-1:0] a, input bit push,
                            input logic [DW-1:0] d, input logic [RW-1:0] r);
        @(negedge clk);
        check("ar_ready_idle", DW'(ar_ready), 1);
        if (push) rq.push_back('{data: d, resp: r});
        ar_valid = 1'b1; ar_address = a;
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    // Waits for r_valid, returning on the sampling edge where it is seen.
    task automatic collect_r(input string tag, input int lat);
        int    n = 0;
        bit    seen = 1'b0;
        rexp_t e;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (r_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_rvalid"}, DW'(seen), 1);
        if (!seen) return;
        if (lat > 0) check({tag, "_latency"}, DW'(n), DW'(lat));
        check({tag, "_sb"}, DW'(rq.size() > 0), 1);
        if (rq.size() == 0) return;
        e = rq.pop_front();
        check({tag, "_rdata"}, r_data, e.data);
        check({tag, "_rresp"}, DW'(r_resp), DW'(e.resp));
    endtask

    task automatic check_b_now(input string tag);
        logic [RW-1:0] e;
        check({tag, "_bvalid"}, DW'(b_valid), 1);
        check({tag, "_sb"}, DW'(bq.size() > 0), 1);
        if (bq.size() == 0) return;
        e = bq.pop_front();
        check({tag, "_bresp"}, DW'(b_resp), DW'(e));
    endtask

    task automatic collect_b(input string tag, input int lat);
        int n = 0;
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (b_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_bvalid"}, DW'(seen), 1);
            return;
        end
        if (lat > 0) check({tag, "_blatency"}, DW'(n), DW'(lat));
        check_b_now(tag);
    endtask

    task automatic write_same(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [RW-1:0] r);
        @(negedge clk);
        check("aw_ready_idle", DW'(aw_ready), 1);
        check("w_ready_idle", DW'(w_ready), 1);
        bq.push_back(r);
        aw_valid = 1'b1; aw_address = a; w_valid = 1'b1; w_data = d;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ar_valid = 1'b0; ar_address = '0; r_ready = 1'b1;
        aw_valid = 1'b0; aw_address = '0; w_valid = 1'b0; w_data = '0; b_ready = 1'b1;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ar_ready", DW'(ar_ready), 1);
        check("rst_aw_ready", DW'(aw_ready), 1);
        check("rst_w_ready", DW'(w_ready), 1);
        check("rst_r_valid", DW'(r_valid), 0);
        check("rst_b_valid", DW'(b_valid), 0);
        check("rst_r_data", r_data, 0);
        rst_n = 1'b1;

        // Basic read with latency.
        dbg_write(4'd3, 32'hA5);
        issue_ar(4'd3, 1'b1, 32'hA5, 1'b0);
        collect_r("rd3", RL + 1);

        // Write data arriving two cycles before the address.
        @(negedge clk);
        bq.push_back(1'b0);
        w_valid = 1'b1; w_data = 32'h1234;
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        check("w_first_aw_ready", DW'(aw_ready), 1);
        check("w_first_w_ready", DW'(w_ready), 0);
        @(negedge clk);
        aw_valid = 1'b1; aw_address = 4'd5;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        collect_b("wr5", 1);
        dbg_check("mem5", 4'd5, 32'h1234);

        // Read stalled by r_ready while an unrelated write completes.
        dbg_write(4'd6, 32'h66);
        r_ready = 1'b0;
        issue_ar(4'd6, 1'b1, 32'h66, 1'b0);
        collect_r("stall6", RL + 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_rvalid", DW'(r_valid), 1);
            check("stall_rdata", r_data, 32'h66);
            check("stall_ar_ready", DW'(ar_ready), 0);
            if (i == 0) begin
                bq.push_back(1'b0);
                aw_valid = 1'b1; aw_address = 4'd9; w_valid = 1'b1; w_data = 32'h99;
            end
            if (i == 1) begin
                check_b_now("wr9");
                aw_valid = 1'b0; w_valid = 1'b0;
            end
        end
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_released", DW'(r_valid), 0);
        dbg_check("mem9", 4'd9, 32'h99);

        // Backdoor and bus write to the same word on the same edge.
        @(negedge clk);
        bq.push_back(1'b0);
        dbg_we = 1'b1; dbg_addr = 4'd10; dbg_wdata = 32'hDD;
        aw_valid = 1'b1; aw_address = 4'd10; w_valid = 1'b1; w_data = 32'hBB;
        @(posedge clk); #1;
        dbg_we = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        collect_b("wr10", 1);
        dbg_check("mem10_bus_wins", 4'd10, 32'hBB);

        // Out-of-range accesses.
        dbg_write(4'd2, 32'h22);
        write_same(4'd14, 32'hFFFF, 1'b1);
        collect_b("wr14", 1);
        dbg_check("mem2_untouched", 4'd2, 32'h22);
        dbg_check("mem14_reads_zero", 4'd14, 32'h0);
        issue_ar(4'd13, 1'b1, 32'h0, 1'b1);
        collect_r("rd13", RL + 1);
        issue_ar(4'd3, 1'b1, 32'hA5, 1'b0);
        collect_r("rd3b", RL + 1);

        // Reset during R_WAIT with only a write address captured.
        dbg_write(4'd4, 32'h44);
        issue_ar(4'd5, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        aw_valid = 1'b1; aw_address = 4'd4;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        @(negedge clk);
        check("aw_only_aw_ready", DW'(aw_ready), 0);
        check("aw_only_ar_ready", DW'(ar_ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ar_ready", DW'(ar_ready), 1);
        check("mid_rst_aw_ready", DW'(aw_ready), 1);
        check("mid_rst_w_ready", DW'(w_ready), 1);
        check("mid_rst_r_valid", DW'(r_valid), 0);
        check("mid_rst_b_valid", DW'(b_valid), 0);
        check("mid_rst_r_data", r_data, 0);
        check("mid_rst_r_resp", DW'(r_resp), 0);
        check("mid_rst_b_resp", DW'(b_resp), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dbg_check("mem4_after_rst", 4'd4, 32'h44);

        // The captured address must be gone: a lone W does not commit.
        @(negedge clk);
        w_valid = 1'b1; w_data = 32'h5555;
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        check("w_only_no_b", DW'(b_valid), 0);
        check("w_only_w_ready", DW'(w_ready), 0);
        bq.push_back(1'b0);
        aw_valid = 1'b1; aw_address = 4'd8;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        collect_b("wr8", 1);
        dbg_check("mem8", 4'd8, 32'h5555);
        dbg_check("mem4_still", 4'd4, 32'h44);

        // Write commit on the edge R_RESP is entered for the same word.
        dbg_write(4'd7, 32'h1);
        issue_ar(4'd7, 1'b1, 32'h1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bq.push_back(1'b0);
        aw_valid = 1'b1; aw_address = 4'd7; w_valid = 1'b1; w_data = 32'h2;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        collect_r("coll7", 1);
        check_b_now("coll7w");
        issue_ar(4'd7, 1'b1, 32'h2, 1'b0);
        collect_r("rd7_new", RL + 1);

        @(negedge clk);
        check("sb_r_drained", DW'(rq.size()), 0);
        check("sb_b_drained", DW'(bq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
